// File: rtl/mat_vec_loader.sv
// Fetches vector B and the rows of matrix A over Avalon-MM (one read in flight),
// then streams B serially and A as a diagonal skewed wavefront across ROWS lanes.
module mat_vec_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic                         stall,
    output logic [ADDR_WIDTH-1:0]        avm_address,
    output logic                         avm_read,
    input  logic [COLS*DATA_WIDTH-1:0]   avm_readdata,
    input  logic                         avm_readdatavalid,
    input  logic                         avm_waitrequest,
    output logic [ROWS*DATA_WIDTH-1:0]   a_data,
    output logic [ROWS-1:0]              a_valid,
    output logic [DATA_WIDTH-1:0]        b_data,
    output logic                         b_valid,
    output logic                         busy,
    output logic                         done
);
    localparam int W_W  = $clog2(ROWS + 1);
    localparam int T_W  = $clog2(ROWS + COLS);
    localparam int T_W1 = T_W + 1;
    localparam int CI_W = $clog2(COLS);
    localparam int RI_W = $clog2(ROWS);
    localparam logic [T_W-1:0] T_LAST = T_W'(ROWS + COLS - 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [W_W-1:0]        r_w, w_w_next;
    logic [T_W-1:0]        r_t, w_t_next;
    logic [DATA_WIDTH-1:0] r_b_buf [COLS];
    logic [DATA_WIDTH-1:0] r_a_buf [ROWS][COLS];
    logic [DATA_WIDTH-1:0] w_elem  [COLS];
    logic [RI_W-1:0]       w_row;
    logic                  w_capture;
    logic                  w_stream_next;
    logic [ROWS-1:0]            w_a_valid_next;
    logic [ROWS*DATA_WIDTH-1:0] w_a_data_next;
    logic                       w_b_valid_next;
    logic [DATA_WIDTH-1:0]      w_b_data_next;

    always_comb begin
        w_state_next = r_state;
        w_w_next     = r_w;
        w_t_next     = r_t;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_REQ;
                    w_w_next     = '0;
                    w_t_next     = '0;
                end
            end
            S_REQ: begin
                if (!avm_waitrequest) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (avm_readdatavalid) begin
                    if (r_w == W_W'(ROWS)) begin
                        w_state_next = S_STREAM;
                        w_t_next     = '0;
                    end else begin
                        w_state_next = S_REQ;
                        w_w_next     = r_w + W_W'(1);
                    end
                end
            end
            S_STREAM: begin
                if (!stall) begin
                    if (r_t == T_LAST) w_state_next = S_DONE;
                    else               w_t_next     = r_t + T_W'(1);
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_capture     = (r_state == S_WAIT) && avm_readdatavalid;
    assign w_row         = RI_W'(r_w - W_W'(1));
    assign w_stream_next = (w_state_next == S_STREAM);

    assign avm_read    = (r_state == S_REQ);
    assign avm_address = avm_read ? (r_base + ADDR_WIDTH'(r_w)) : '0;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);

    genvar gi;
    // Element 0 sits in the most significant lane of the memory word.
    for (gi = 0; gi < COLS; gi++) begin : g_elem
        assign w_elem[gi] = avm_readdata[(COLS-1-gi)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Lane r carries A[r][t-r] while 0 <= t-r < COLS; the sign bit of the
    // difference rejects lanes the wavefront has not reached yet.
    for (gi = 0; gi < ROWS; gi++) begin : g_lane
        logic [T_W:0] w_diff;
        logic         w_hit;
        assign w_diff = {1'b0, w_t_next} - T_W1'(gi);
        assign w_hit  = w_stream_next && !w_diff[T_W] && (w_diff[T_W-1:0] < T_W'(COLS));
        assign w_a_valid_next[gi] = w_hit;
        assign w_a_data_next[gi*DATA_WIDTH +: DATA_WIDTH] =
            w_hit ? r_a_buf[gi][CI_W'(w_diff[T_W-1:0])] : '0;
    end

    assign w_b_valid_next = w_stream_next && (w_t_next < T_W'(COLS));
    assign w_b_data_next  = w_b_valid_next ? r_b_buf[CI_W'(w_t_next)] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_w     <= '0;
            r_t     <= '0;
            a_valid <= '0;
            a_data  <= '0;
            b_valid <= 1'b0;
            b_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_w     <= w_w_next;
            r_t     <= w_t_next;
            if (r_state == S_IDLE && start) r_base <= base_addr;
            a_valid <= w_a_valid_next;
            a_data  <= w_a_data_next;
            b_valid <= w_b_valid_next;
            b_data  <= w_b_data_next;
        end
    end

    // Word 0 of a job is vector B; word k lands in A row k-1.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int j = 0; j < COLS; j++) begin
                if (r_w == '0) r_b_buf[j]        <= w_elem[j];
                else           r_a_buf[w_row][j] <= w_elem[j];
            end
        end
    end
endmodule

// File: tb/tb_mat_vec_loader.sv
// Directed bench for mat_vec_loader: default-size instance plus a 4x2, 16-bit instance,
// each with an Avalon-MM memory responder.
module tb_mat_vec_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, stall;
    logic [31:0] base_addr, avm_address;
    logic        avm_read, avm_readdatavalid, avm_waitrequest;
    logic [63:0] avm_readdata, a_data;
    logic [7:0]  a_valid, b_data;
    logic        b_valid, busy, done;

    logic        start1, stall1;
    logic [31:0] base_addr1, avm_address1, avm_readdata1;
    logic        avm_read1, rdv1, wr1;
    logic [63:0] a_data1;
    logic [3:0]  a_valid1;
    logic [15:0] b_data1;
    logic        b_valid1, busy1, done1;

    mat_vec_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .stall(stall),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .a_data(a_data), .a_valid(a_valid), .b_data(b_data), .b_valid(b_valid),
        .busy(busy), .done(done)
    );

    mat_vec_loader #(.DATA_WIDTH(16), .ROWS(4), .COLS(2), .ADDR_WIDTH(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .base_addr(base_addr1), .stall(stall1),
        .avm_address(avm_address1), .avm_read(avm_read1), .avm_readdata(avm_readdata1),
        .avm_readdatavalid(rdv1), .avm_waitrequest(wr1),
        .a_data(a_data1), .a_valid(a_valid1), .b_data(b_data1), .b_valid(b_valid1),
        .busy(busy1), .done(done1)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory contents: 0x1xx word k = {8{k+1}}, 0x0xx word k = {8{0x41+k}},
    // 0x2xx element j of word k = {k[3:0], j[3:0]}.
    function automatic logic [7:0] elem0(input logic [31:0] a, input int j);
        case (a[9:8])
            2'd1:    return a[7:0] + 8'd1;
            2'd0:    return a[7:0] + 8'h41;
            default: return {a[3:0], 4'(j)};
        endcase
    endfunction

    function automatic logic [63:0] word0(input logic [31:0] a);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[(7-j)*8 +: 8] = elem0(a, j);
        return w;
    endfunction

    function automatic logic [15:0] elem1(input logic [31:0] a, input int j);
        return 16'hA000 | {4'h0, a[7:0], 4'(j)};
    endfunction

    int          mem_wait = 0;
    int          mem_lat  = 1;
    logic        inj_rdv  = 1'b0;
    logic [31:0] acc_q[$];
    logic [31:0] acc1_q[$];

    initial begin
        int wcnt;
        int pend_cnt;
        logic [31:0] pend_addr;
        logic [31:0] hold_addr;
        wcnt = 0; pend_cnt = 0; pend_addr = '0; hold_addr = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(posedge clk); #1;
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = word0(pend_addr);
                end
            end else if (inj_rdv) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = {8{8'hEE}};
            end
            if (avm_waitrequest) begin
                check("hold_read", 64'(avm_read), 64'(1'b1));
                check("hold_addr", 64'(avm_address), 64'(hold_addr));
            end
            if (avm_read) begin
                if (wcnt < mem_wait) begin
                    avm_waitrequest = 1'b1;
                    wcnt++;
                    hold_addr = avm_address;
                end else begin
                    avm_waitrequest = 1'b0;
                    wcnt = 0;
                    pend_cnt = mem_lat;
                    pend_addr = avm_address;
                    acc_q.push_back(avm_address);
                end
            end else begin
                avm_waitrequest = 1'b0;
            end
        end
    end

    initial begin
        logic        acc1;
        logic [31:0] addr1;
        acc1 = 1'b0; addr1 = '0;
        rdv1 = 1'b0; avm_readdata1 = '0;
        forever begin
            @(posedge clk); #1;
            rdv1 = 1'b0;
            avm_readdata1 = '0;
            if (acc1) begin
                rdv1 = 1'b1;
                avm_readdata1 = {elem1(addr1, 0), elem1(addr1, 1)};
                acc1 = 1'b0;
            end
            if (avm_read1) begin
                acc1 = 1'b1;
                addr1 = avm_address1;
                acc1_q.push_back(avm_address1);
            end
        end
    end

    task automatic run_job(input logic [31:0] base, input int stall_at, input int stall_len,
                           input int poke_t, input int exp_len);
        int t, stalls, cyc, guard;
        logic [7:0]  eav;
        logic [63:0] ead;
        logic        ebv;
        logic [7:0]  ebd;
        acc_q.delete();
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1'b1));
        guard = 0;
        while (!b_valid && guard < 300) begin
            @(posedge clk); #2;
            guard++;
        end
        check("stream_reached", 64'(guard < 300), 64'(1'b1));
        t = 0; stalls = 0; cyc = 0;
        while (t <= 14 && cyc < 40) begin
            eav = '0; ead = '0;
            for (int r = 0; r < 8; r++) begin
                if (t >= r && t < r + 8) begin
                    eav[r] = 1'b1;
                    ead[r*8 +: 8] = elem0(base + 32'(1 + r), t - r);
                end
            end
            ebv = (t < 8);
            ebd = ebv ? elem0(base, t) : 8'h00;
            check("a_valid", 64'(a_valid), 64'(eav));
            check("a_data", a_data, ead);
            check("b_valid", 64'(b_valid), 64'(ebv));
            check("b_data", 64'(b_data), 64'(ebd));
            check("done_early", 64'(done), 64'(1'b0));
            stall   = (t == stall_at && stalls < stall_len);
            start   = (t == poke_t);
            inj_rdv = (t == poke_t);
            if (stall) stalls++;
            else       t++;
            cyc++;
            @(posedge clk); #2;
        end
        stall = 1'b0; start = 1'b0; inj_rdv = 1'b0;
        check("stream_len", 64'(cyc), 64'(exp_len));
        check("done_pulse", 64'(done), 64'(1'b1));
        check("done_a_valid", 64'(a_valid), 64'(0));
        check("done_b_valid", 64'(b_valid), 64'(1'b0));
        start = (poke_t >= 0);
        @(posedge clk); #2;
        start = 1'b0;
        check("done_low", 64'(done), 64'(1'b0));
        check("idle_after_done", 64'(busy), 64'(1'b0));
        check("read_count", 64'(acc_q.size()), 64'(9));
        for (int k = 0; k < acc_q.size() && k < 9; k++)
            check("read_addr", 64'(acc_q[k]), 64'(base + 32'(k)));
        $display("[TB] job base=%h reads=%0d stream_cycles=%0d", base, acc_q.size(), cyc);
    endtask

    task automatic run_job1(input logic [31:0] base);
        int guard;
        logic [3:0]  eav;
        logic [63:0] ead;
        logic        ebv;
        logic [15:0] ebd;
        acc1_q.delete();
        base_addr1 = base;
        start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        guard = 0;
        while (!b_valid1 && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        check("s_stream_reached", 64'(guard < 100), 64'(1'b1));
        for (int t = 0; t <= 4; t++) begin
            eav = '0; ead = '0;
            for (int r = 0; r < 4; r++) begin
                if (t >= r && t < r + 2) begin
                    eav[r] = 1'b1;
                    ead[r*16 +: 16] = elem1(base + 32'(1 + r), t - r);
                end
            end
            ebv = (t < 2);
            ebd = ebv ? elem1(base, t) : 16'h0000;
            check("s_a_valid", 64'(a_valid1), 64'(eav));
            check("s_a_data", a_data1, ead);
            check("s_b_valid", 64'(b_valid1), 64'(ebv));
            check("s_b_data", 64'(b_data1), 64'(ebd));
            @(posedge clk); #2;
        end
        check("s_done_pulse", 64'(done1), 64'(1'b1));
        check("s_done_a_valid", 64'(a_valid1), 64'(0));
        @(posedge clk); #2;
        check("s_done_low", 64'(done1), 64'(1'b0));
        check("s_idle", 64'(busy1), 64'(1'b0));
        check("s_read_count", 64'(acc1_q.size()), 64'(5));
        for (int k = 0; k < acc1_q.size() && k < 5; k++)
            check("s_read_addr", 64'(acc1_q[k]), 64'(base + 32'(k)));
        $display("[TB] small job base=%h reads=%0d", base, acc1_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; stall = 1'b0;
        start1 = 1'b0; base_addr1 = '0; stall1 = 1'b0; wr1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_avm_read", 64'(avm_read), 64'(1'b0));
        check("rst_avm_address", 64'(avm_address), 64'(0));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_a_valid", 64'(a_valid), 64'(0));
        check("rst_a_data", a_data, 64'(0));
        check("rst_b_valid", 64'(b_valid), 64'(1'b0));
        check("rst_b_data", 64'(b_data), 64'(0));
        check("rst_busy1", 64'(busy1), 64'(1'b0));
        reset_n = 1'b1;
        @(posedge clk); #2;
        check("idle_busy", 64'(busy), 64'(1'b0));

        run_job(32'h100, -1, 0, -1, 15);
        mem_wait = 3;
        run_job(32'h100, -1, 0, -1, 15);
        mem_wait = 0;
        run_job(32'h100, 4, 2, -1, 17);
        run_job(32'h200, -1, 0, 5, 15);

        // Stray read responses while idle must not wake the loader.
        acc_q.delete();
        inj_rdv = 1'b1;
        repeat (2) begin
            @(posedge clk); #2;
            check("spur_busy", 64'(busy), 64'(1'b0));
            check("spur_read", 64'(avm_read), 64'(1'b0));
        end
        inj_rdv = 1'b0;
        @(posedge clk); #2;
        check("spur_b_valid", 64'(b_valid), 64'(1'b0));
        check("spur_a_valid", 64'(a_valid), 64'(0));
        check("spur_reads", 64'(acc_q.size()), 64'(0));

        // Reset while the first read is outstanding; its response lands after release.
        acc_q.delete();
        mem_lat = 4;
        base_addr = 32'h100;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        guard = 0;
        while (avm_read && guard < 20) begin
            @(posedge clk); #2;
            guard++;
        end
        check("rst_in_wait", 64'(guard), 64'(1));
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'(1'b0));
        check("async_rst_read", 64'(avm_read), 64'(1'b0));
        @(posedge clk); #2;
        check("rst_hold_read", 64'(avm_read), 64'(1'b0));
        @(posedge clk); #2;
        reset_n = 1'b1;
        mem_lat = 1;
        repeat (3) begin
            @(posedge clk); #2;
            check("late_rsp_busy", 64'(busy), 64'(1'b0));
            check("late_rsp_read", 64'(avm_read), 64'(1'b0));
            check("late_rsp_b_valid", 64'(b_valid), 64'(1'b0));
        end
        check("late_rsp_reads", 64'(acc_q.size()), 64'(1));
        run_job(32'h0, -1, 0, -1, 15);

        run_job1(32'h40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mat_vec_loader.md
MAT_VEC_LOADER -- requirements
Module: mat_vec_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter ROWS, default 8, number of matrix-A rows and output lanes (2..16).
REQ-003 SHALL have parameter COLS, default 8, elements per memory word and per vector (2..16).
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, Avalon word-address width.
REQ-005 SHALL fix memory word width at COLS*DATA_WIDTH; no separate parameter.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  begin a load/stream job; sampled in IDLE only.
REQ-009 base_addr  input  ADDR_WIDTH  word address of vector B; A row r at base_addr+1+r; sampled with start.
REQ-010 stall  input  1  freezes the stream counter and holds all stream outputs while high.
REQ-011 avm_address  output  ADDR_WIDTH  Avalon-MM read address.
REQ-012 avm_read  output  1  Avalon-MM read request.
REQ-013 avm_readdata  input  COLS*DATA_WIDTH  read data word.
REQ-014 avm_readdatavalid  input  1  read data valid.
REQ-015 avm_waitrequest  input  1  slave busy; request held while high.
REQ-016 a_data  output  ROWS*DATA_WIDTH  lane r in bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-017 a_valid  output  ROWS  per-lane valid.
REQ-018 b_data  output  DATA_WIDTH  vector-B element stream.
REQ-019 b_valid  output  1  b_data valid.
REQ-020 busy  output  1  high in any state other than IDLE.
REQ-021 done  output  1  one-cycle pulse at job completion.

Function
REQ-022 SHALL implement states IDLE, REQ, WAIT, STREAM, DONE.
REQ-023 IDLE: on start=1, latch base_addr, clear word index w=0, go to REQ next cycle.
REQ-024 REQ: avm_read=1, avm_address=base+w; stay while avm_waitrequest=1; go to WAIT on the cycle avm_waitrequest=0.
REQ-025 SHALL keep at most one read outstanding; avm_read=0 outside REQ.
REQ-026 WAIT: on avm_readdatavalid=1 store the word (w=0 into B buffer, w=k into A row k-1); if w=ROWS go to STREAM, else increment w and return to REQ.
REQ-027 Element j of a word SHALL be bits [(COLS-1-j)*DATA_WIDTH +: DATA_WIDTH] (element 0 is the MSB lane).
REQ-028 avm_readdatavalid outside WAIT SHALL be ignored and SHALL NOT corrupt buffers.
REQ-029 STREAM: counter t starts at 0, increments each cycle stall=0, holds when stall=1.
REQ-030 Lane r SHALL be valid iff r <= t < r+COLS, carrying A[r][t-r]; otherwise a_valid[r]=0 and lane data 0.
REQ-031 b_valid SHALL be 1 iff t < COLS, with b_data=B[t]; otherwise 0.
REQ-032 Outputs SHALL be registered: values for t appear the cycle t is held in the counter; first valid cycle is the cycle after WAIT exits.
REQ-033 When t = ROWS+COLS-2 and stall=0, go to DONE; DONE asserts done=1 for one cycle and returns to IDLE.
REQ-034 start during any non-IDLE state SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-035 A new job SHALL fully overwrite both buffers; no stale data SHALL reach outputs.

Reset
REQ-036 reset_n=0 SHALL asynchronously force state IDLE, w=0, t=0, avm_read=0, avm_address=0, a_valid=0, a_data=0, b_valid=0, b_data=0, done=0, busy=0.
REQ-037 Reset mid-job SHALL abandon the job; a read response arriving after reset release SHALL be ignored (IDLE).

Verification
REQ-038 Defaults, base_addr=0x100, zero-wait memory, word k = {8{k+1}} bytes -> reads at 0x100..0x108 in order; b_data 1 for t=0..7; lane 3 valid t=3..10 with value 5; done one cycle after t=14.
REQ-039 avm_waitrequest high 3 cycles on each request -> avm_address/avm_read held stable throughout; same output data as REQ-038.
REQ-040 stall high 2 cycles at t=4 -> all a_valid/a_data/b_* held for 2 extra cycles; total STREAM length 17 cycles.
REQ-041 start pulsed during STREAM and spurious readdatavalid in IDLE -> no new read, no buffer change, single done.
REQ-042 reset_n low while in WAIT, then start new job at base 0x0 -> avm_read=0 during reset, late response ignored, second job outputs match memory at 0x0..0x8.
REQ-043 ROWS=4, COLS=2, DATA_WIDTH=16 -> 5 reads, lane r valid t=r..r+1, done after t=4.
